// File: rtl/mmio_pkg.sv
// Shared address map, control-register bit positions and the UART state
// encoding used by both the transmitter and the receiver.
package mmio_pkg;

  localparam logic [31:0] MMIO_CTRL    = 32'h8000_0000;
  localparam logic [31:0] MMIO_RX      = 32'h8000_0004;
  localparam logic [31:0] MMIO_TX      = 32'h8000_0008;
  localparam logic [31:0] MMIO_CYC     = 32'h8000_0010;
  localparam logic [31:0] MMIO_INST    = 32'h8000_0014;
  localparam logic [31:0] MMIO_CNT_RST = 32'h8000_0018;

  localparam int CTRL_TX_READY = 0;
  localparam int CTRL_RX_VALID = 1;
  localparam int CTRL_OVERRUN  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: mid-bit sampling, glitch rejection on the start bit, and a
// one-cycle done pulse (with framing-error flag) when the stop bit is sampled.
module uart_rx
  import mmio_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_i,
  output logic [7:0] byte_o,
  output logic       done_o,
  output logic       frame_err_o
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          done_q, done_d;
  logic          ferr_q, ferr_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!serial_i) state_d = START;
      end
      START: begin
        // Re-check the line half a bit in; a high level means it was a glitch.
        if (cnt_q == HALF_END) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = serial_i ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          shift_d = {serial_i, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          state_d = IDLE;
          done_d  = 1'b1;
          ferr_d  = !serial_i;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  assign byte_o      = shift_q;
  assign done_o      = done_q;
  assign frame_err_o = ferr_q;

endmodule

// File: rtl/mmio_uart_ctrl.sv
// MMIO block: address decode, registered read mux, UART TX, cycle/instret counters.
// Define UART_OVERRUN_FLAG_EN to add the sticky RX overrun flag at control bit 2.
module mmio_uart_ctrl
  import mmio_pkg::*;
#(
  parameter int CPU_CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE      = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        serial_in,
  output logic        serial_out,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wea,
  input  logic        re,
  input  logic        inst_retire,
  output logic [31:0] rdata
);

  localparam int CLKS_PER_BIT = CPU_CLOCK_FREQ / BAUD_RATE;
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);

  logic [29:0] word_addr;
  logic        we;
  logic        hit_ctrl, hit_rx, hit_tx, hit_cyc, hit_inst, hit_cnt_rst;
  logic        tx_wr, cnt_rst_wr, rx_rd, rx_set, tx_ready;
  logic        unused_bits;

  assign word_addr   = addr[31:2];
  assign we          = |wea;
  assign hit_ctrl    = (word_addr == MMIO_CTRL[31:2]);
  assign hit_rx      = (word_addr == MMIO_RX[31:2]);
  assign hit_tx      = (word_addr == MMIO_TX[31:2]);
  assign hit_cyc     = (word_addr == MMIO_CYC[31:2]);
  assign hit_inst    = (word_addr == MMIO_INST[31:2]);
  assign hit_cnt_rst = (word_addr == MMIO_CNT_RST[31:2]);
  assign tx_wr       = we && hit_tx;
  assign cnt_rst_wr  = we && hit_cnt_rst;
  assign rx_rd       = re && hit_rx;
  assign unused_bits = ^{addr[1:0], wdata[31:8]};

  // Receiver
  logic [7:0] rx_byte;
  logic       rx_done, rx_ferr;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .serial_i   (serial_in),
    .byte_o     (rx_byte),
    .done_o     (rx_done),
    .frame_err_o(rx_ferr)
  );

  assign rx_set = rx_done && !rx_ferr;

  // Transmitter
  uart_state_e   tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;

  assign tx_ready = (tx_state_q == IDLE);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 1'b1;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    case (tx_state_q)
      IDLE: begin
        tx_cnt_d = '0;
        if (tx_wr) begin
          tx_state_d = START;
          tx_shift_d = wdata[7:0];
        end
      end
      START: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = DATA;
        end
      end
      DATA: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_state_d = STOP;
        end
      end
      STOP: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d   = '0;
          tx_state_d = IDLE;
        end
      end
      default: tx_state_d = IDLE;
    endcase
  end

  always_comb begin
    serial_out = 1'b1;
    case (tx_state_q)
      START:   serial_out = 1'b0;
      DATA:    serial_out = tx_shift_q[0];
      default: serial_out = 1'b1;
    endcase
  end

  // Counters, RX holding register and read port
  logic [31:0] cyc_q, inst_q;
  logic        rx_valid_q;
  logic [7:0]  rx_byte_q;
  logic [31:0] rdata_q, rdata_d;

`ifdef UART_OVERRUN_FLAG_EN
  logic ovr_q;
  logic ctrl_rd;
  assign ctrl_rd = re && hit_ctrl;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_q <= 1'b0;
    end else if (rx_set && rx_valid_q && !rx_rd) begin
      ovr_q <= 1'b1;
    end else if (ctrl_rd) begin
      ovr_q <= 1'b0;
    end
  end
`endif

  always_comb begin
    rdata_d = '0;
    if (hit_ctrl) begin
      rdata_d[CTRL_TX_READY] = tx_ready;
      rdata_d[CTRL_RX_VALID] = rx_valid_q;
`ifdef UART_OVERRUN_FLAG_EN
      rdata_d[CTRL_OVERRUN]  = ovr_q;
`endif
    end else if (hit_rx) begin
      rdata_d = {24'b0, rx_byte_q};
    end else if (hit_cyc) begin
      rdata_d = cyc_q;
    end else if (hit_inst) begin
      rdata_d = inst_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      cyc_q      <= '0;
      inst_q     <= '0;
      rx_valid_q <= 1'b0;
      rx_byte_q  <= '0;
      rdata_q    <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      if (cnt_rst_wr) begin
        cyc_q  <= '0;
        inst_q <= '0;
      end else begin
        cyc_q <= cyc_q + 32'd1;
        if (inst_retire) inst_q <= inst_q + 32'd1;
      end
      // A completing byte beats a same-cycle read; the read still sees the old byte.
      if (rx_set) begin
        rx_valid_q <= 1'b1;
        rx_byte_q  <= rx_byte;
      end else if (rx_rd) begin
        rx_valid_q <= 1'b0;
      end
      if (re) rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// Self-checking bench for mmio_uart_ctrl with a cycle-level reference model.
module tb_mmio_uart_ctrl;
  import mmio_pkg::*;

  localparam int CPB = 10;

  logic        clk = 1'b0;
  logic        rst, serial_in, serial_out, re, inst_retire;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  wea;

  always #5 clk = ~clk;

  mmio_uart_ctrl #(.CPU_CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000)) dut (
    .clk        (clk),
    .rst        (rst),
    .serial_in  (serial_in),
    .serial_out (serial_out),
    .addr       (addr),
    .wdata      (wdata),
    .wea        (wea),
    .re         (re),
    .inst_retire(inst_retire),
    .rdata      (rdata)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state
  longint      n = 0;
  longint      tx_start = 0, tx_end = 0;
  logic [7:0]  tx_byte_m = '0;
  logic [31:0] cyc_m = '0, inst_m = '0, exp_rdata = '0;
  logic        rx_valid_m = 1'b0, ovr_m = 1'b0;
  logic [7:0]  rx_byte_m = '0;
  bit          chk_on = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", nm, act, exp, n);
    end
  endtask

  function automatic bit hit(input logic [31:0] a, input logic [31:0] base);
    return a[31:2] == base[31:2];
  endfunction

  // Line level after edge m: start bit, 8 data bits LSB first, stop bit.
  function automatic logic exp_serial(input longint m);
    longint k;
    if (m < tx_start || m >= tx_end) return 1'b1;
    k = (m - tx_start) / CPB;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return tx_byte_m[int'(k) - 1];
  endfunction

  always @(posedge clk) begin
    bit tx_idle;
    tx_idle = !((n >= tx_start) && (n < tx_end));
    n = n + 1;
    if (rst) begin
      exp_rdata = '0; cyc_m = '0; inst_m = '0;
      rx_valid_m = 1'b0; rx_byte_m = '0; ovr_m = 1'b0;
      tx_start = n; tx_end = n;
    end else begin
      if (re) begin
        if (hit(addr, MMIO_CTRL))      exp_rdata = {29'b0, ovr_m, rx_valid_m, tx_idle};
        else if (hit(addr, MMIO_RX))   exp_rdata = {24'b0, rx_byte_m};
        else if (hit(addr, MMIO_CYC))  exp_rdata = cyc_m;
        else if (hit(addr, MMIO_INST)) exp_rdata = inst_m;
        else                           exp_rdata = '0;
        if (hit(addr, MMIO_RX))   rx_valid_m = 1'b0;
        if (hit(addr, MMIO_CTRL)) ovr_m = 1'b0;
      end
      if (wea != 4'b0 && hit(addr, MMIO_CNT_RST)) begin
        cyc_m = '0; inst_m = '0;
      end else begin
        cyc_m = cyc_m + 1;
        if (inst_retire) inst_m = inst_m + 1;
      end
      if (wea != 4'b0 && hit(addr, MMIO_TX) && tx_idle) begin
        tx_start = n; tx_end = n + 10 * CPB; tx_byte_m = wdata[7:0];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("rdata", rdata, exp_rdata);
      check("serial_out", 32'(serial_out), 32'(exp_serial(n)));
    end
  end

  task automatic rd(input logic [31:0] a, input logic [31:0] lit, input string nm);
    addr = a; re = 1'b1;
    @(negedge clk);
    re = 1'b0; addr = '0;
    check(nm, rdata, lit);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; wea = 4'hF;
    @(negedge clk);
    wea = 4'h0; addr = '0; wdata = '0;
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop);
    serial_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      repeat (CPB) @(negedge clk);
    end
    serial_in = stop;
    repeat (CPB) @(negedge clk);
    serial_in = 1'b1;
    if (stop) begin
`ifdef UART_OVERRUN_FLAG_EN
      if (rx_valid_m) ovr_m = 1'b1;
`endif
      rx_valid_m = 1'b1;
      rx_byte_m  = b;
    end
    repeat (30) @(negedge clk);
  endtask

  logic [9:0]  frame_lit = 10'b1101001010;
  logic [19:0] retire_pat = 20'b1001_0010_0101_0001_0001;
  logic [31:0] ctrl_ovr_lit;

  initial begin
    rst = 1'b1; serial_in = 1'b1; addr = '0; wdata = '0; wea = '0; re = 1'b0; inst_retire = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0; chk_on = 1'b1;
    check("serial_out_rst", 32'(serial_out), 32'h1);
    check("rdata_rst", rdata, 32'h0);
    rd(MMIO_CTRL, 32'h1, "ctrl_after_rst");
    rd(MMIO_TX, 32'h0, "tx_reg_reads0");
    rd(32'h8000_001C, 32'h0, "unmapped_read");

    // TX frame 0xA5, with a busy status read and a dropped second write inside it
    wr(MMIO_TX, 32'hA5);
    repeat (5) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      check("tx_bit", 32'(serial_out), 32'(frame_lit[k]));
      if (k == 2) begin
        rd(MMIO_CTRL, 32'h0, "ctrl_tx_busy");
        repeat (9) @(negedge clk);
      end else if (k == 4) begin
        wr(MMIO_TX, 32'h0F);
        repeat (9) @(negedge clk);
      end else if (k < 9) begin
        repeat (10) @(negedge clk);
      end
    end
    repeat (4) @(negedge clk);
    rd(MMIO_CTRL, 32'h0, "ctrl_last_stop_cycle");
    rd(MMIO_CTRL, 32'h1, "ctrl_tx_ready_back");
    repeat (20) @(negedge clk);

    // Reset in the middle of a frame
    wr(MMIO_TX, 32'h00);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_abort_serial", 32'(serial_out), 32'h1);
    rd(MMIO_CTRL, 32'h1, "ctrl_after_abort");

    // Receive
    rx_frame(8'h3C, 1'b1);
    rd(MMIO_CTRL, 32'h3, "ctrl_rx_valid");
    rd(MMIO_RX, 32'h3C, "rx_byte_3c");
    rd(MMIO_CTRL, 32'h1, "ctrl_rx_cleared");

    rx_frame(8'h11, 1'b1);
    rx_frame(8'h22, 1'b1);
`ifdef UART_OVERRUN_FLAG_EN
    ctrl_ovr_lit = 32'h7;
`else
    ctrl_ovr_lit = 32'h3;
`endif
    rd(MMIO_CTRL, ctrl_ovr_lit, "ctrl_two_frames");
    rd(MMIO_CTRL, 32'h3, "ctrl_ovr_cleared");
    rd(MMIO_RX, 32'h22, "rx_byte_overwritten");
    rd(MMIO_CTRL, 32'h1, "ctrl_after_rx_read");

    serial_in = 1'b0;
    repeat (4) @(negedge clk);
    serial_in = 1'b1;
    repeat (30) @(negedge clk);
    rd(MMIO_CTRL, 32'h1, "ctrl_after_glitch");

    rx_frame(8'h5A, 1'b0);
    rd(MMIO_CTRL, 32'h1, "ctrl_after_frame_err");
    rd(MMIO_RX, 32'h22, "rx_byte_kept");

    // Counters
    wr(MMIO_CNT_RST, 32'h1);
    for (int i = 0; i < 20; i++) begin
      inst_retire = retire_pat[i];
      @(negedge clk);
    end
    inst_retire = 1'b0;
    rd(MMIO_CYC, 32'd20, "cycle_count");
    rd(MMIO_INST, 32'd7, "inst_count");
    inst_retire = 1'b1;
    wr(MMIO_CNT_RST, 32'h0);
    inst_retire = 1'b0;
    rd(MMIO_CYC, 32'd0, "cycle_after_clear");
    rd(MMIO_INST, 32'd0, "inst_after_clear");

    force dut.cyc_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.cyc_q;
    cyc_m = 32'hFFFF_FFFF;
    rd(MMIO_CYC, 32'hFFFF_FFFF, "cycle_max");
    rd(MMIO_CYC, 32'h0, "cycle_wrapped");
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
